// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: shared state encoding and constants for the Wishbone copy engine.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        DONE
    } state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [3:0]  SEL_ALL    = 4'hF;
    localparam logic [31:0] ADDR_MASK  = ~(WORD_BYTES - 32'd1);

    function automatic logic is_bus(input state_t s);
        return (s == RD) || (s == WR);
    endfunction

endpackage

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: word-by-word Wishbone memory copy, one read then one write per word.
// Define WB_DMA_TIMEOUT_EN to abort a transfer that waits TIMEOUT cycles for ack.
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [31:0]      o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_stb,
    output logic             o_wb_cyc,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack
);

    state_t           state;
    state_t           state_n;
    logic [31:0]      src;
    logic [31:0]      src_n;
    logic [31:0]      dst;
    logic [31:0]      dst_n;
    logic [31:0]      data;
    logic [31:0]      data_n;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_n;
    logic             bus;
    logic             tout;

    logic             stb_n;
    logic             we_n;
    logic             busy_n;
    logic             done_n;
    logic [3:0]       sel_n;
    logic [31:0]      adr_n;
    logic [31:0]      dat_n;

    assign bus = is_bus(state);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            src   <= src_n;
            dst   <= dst_n;
            cnt   <= cnt_n;
            data  <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        cnt_n   = cnt;
        data_n  = data;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    src_n   = i_src & ADDR_MASK;
                    dst_n   = i_dst & ADDR_MASK;
                    cnt_n   = i_len;
                    state_n = (i_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (i_wb_ack) begin
                    data_n  = i_wb_rdt;
                    state_n = RD_GAP;
                end else if (tout) begin
                    state_n = DONE;
                end
            end
            RD_GAP: state_n = WR;
            WR: begin
                if (i_wb_ack) begin
                    state_n = WR_GAP;
                end else if (tout) begin
                    state_n = DONE;
                end
            end
            WR_GAP: begin
                src_n   = src + WORD_BYTES;
                dst_n   = dst + WORD_BYTES;
                cnt_n   = cnt - LEN_W'(1);
                state_n = (cnt == LEN_W'(1)) ? DONE : RD;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef WB_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tcnt;

    // tcnt counts strobe cycles already spent without ack in this transfer
    assign tout = bus && !i_wb_ack && (tcnt == T_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tcnt <= '0;
        end else if (bus && !i_wb_ack && !tout) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (state == IDLE && i_start) begin
            o_err <= 1'b0;
        end else if (tout) begin
            o_err <= 1'b1;
        end
    end
`else
    assign tout  = 1'b0;
    assign o_err = 1'b0;
`endif

    // Bus outputs are derived from the next state so they leave a flop
    always_comb begin
        stb_n  = is_bus(state_n);
        we_n   = (state_n == WR);
        sel_n  = stb_n ? SEL_ALL : 4'h0;
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
        adr_n  = o_wb_adr;
        dat_n  = o_wb_dat;
        if (state_n == RD) begin
            adr_n = src_n;
        end
        if (state_n == WR) begin
            adr_n = dst_n;
            dat_n = data_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
        end else begin
            o_busy   <= busy_n;
            o_done   <= done_n;
            o_wb_stb <= stb_n;
            o_wb_cyc <= stb_n;
            o_wb_we  <= we_n;
            o_wb_sel <= sel_n;
            o_wb_adr <= adr_n;
            o_wb_dat <= dat_n;
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: randomized bench with a Wishbone RAM responder and copy model.
// Define WB_DMA_TIMEOUT_EN to also exercise the ack timeout path.
module tb_wb_dma_copy;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src = '0;
    logic [31:0]      dst = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      wb_adr;
    logic [31:0]      wb_dat;
    logic [31:0]      wb_rdt = '0;
    logic [3:0]       wb_sel;
    logic             wb_we;
    logic             wb_stb;
    logic             wb_cyc;
    logic             wb_ack;
    logic             ack = 1'b0;
    logic             ack_en = 1'b1;
    logic             stray_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    logic [31:0] mem     [1024];
    logic [31:0] exp_mem [1024];

    int          done_cnt = 0;
    int          stb_cycles = 0;
    int          first_stb = -1;
    int          done_cyc = 0;
    int          viol = 0;
    logic [31:0] rd_q [$];
    logic        prev_stb = 1'b0;
    logic        prev_ack = 1'b0;
    logic [64:0] prev_bus = '0;

    always #5 clk = ~clk;

    // stray acks appear only while the strobe is low and must be ignored
    assign wb_ack = ack | (stray_en & ~wb_stb);

    wb_dma_copy #(
        .LEN_W  (LEN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_src   (src),
        .i_dst   (dst),
        .i_len   (len),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .o_wb_adr(wb_adr),
        .o_wb_dat(wb_dat),
        .o_wb_sel(wb_sel),
        .o_wb_we (wb_we),
        .o_wb_stb(wb_stb),
        .o_wb_cyc(wb_cyc),
        .i_wb_rdt(wb_rdt),
        .i_wb_ack(wb_ack)
    );

    // RAM responder: ack one cycle after strobe, write commits on ack
    always @(posedge clk) begin
        cyc_cnt++;
        if (wb_stb && wb_cyc && wb_we && ack) begin
            mem[wb_adr[11:2]] = wb_dat;
        end
        if (!rst_n) begin
            ack <= 1'b0;
        end else if (wb_stb && wb_cyc && ack_en && !ack) begin
            ack    <= 1'b1;
            wb_rdt <= mem[wb_adr[11:2]];
        end else begin
            ack <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
        if (wb_stb) begin
            stb_cycles++;
            if (first_stb < 0) first_stb = cyc_cnt;
            if (!wb_we && !prev_stb) rd_q.push_back(wb_adr);
        end
        if (prev_stb && !prev_ack && wb_stb && ({wb_we, wb_adr, wb_dat} != prev_bus))
            viol++;
        if (prev_stb && prev_ack && wb_stb)
            viol++;
        prev_stb = wb_stb;
        prev_ack = wb_ack;
        prev_bus = {wb_we, wb_adr, wb_dat};
    end

    task automatic clear_stats();
        done_cnt   = 0;
        stb_cycles = 0;
        first_stb  = -1;
        done_cyc   = 0;
        viol       = 0;
        rd_q.delete();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    endtask

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                              input int n);
        logic [31:0] a;
        logic [31:0] b;
        a = s & 32'hFFFF_FFFC;
        b = d & 32'hFFFF_FFFC;
        for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
        for (int i = 0; i < n; i++) begin
            exp_mem[b[11:2]] = exp_mem[a[11:2]];
            a = a + 32'd4;
            b = b + 32'd4;
        end
    endtask

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                              input logic [LEN_W-1:0] n);
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, wb_stb, wb_cyc, wb_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, done, err, wb_stb, wb_cyc, wb_we});
        end
        checks++;
        if (wb_sel !== 4'h0) begin
            errors++;
            $display("FAIL reset_sel: got %h expected 0", wb_sel);
        end
        checks++;
        if (wb_adr !== 32'h0) begin
            errors++;
            $display("FAIL reset_adr: got %h expected 0", wb_adr);
        end
        checks++;
        if (wb_dat !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat: got %h expected 0", wb_dat);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] want;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | i;
        for (int k = 0; k < 4; k++) mem[64 + k] = 32'h1111_1111 * (k + 1);
        model_copy(32'h100, 32'h200, 4);
        clear_stats();
        start_copy(32'h100, 32'h200, 4);
        wait_done(200);
        for (int k = 0; k < 4; k++) begin
            want = 32'h1111_1111 * (k + 1);
            checks++;
            if (mem[128 + k] !== want) begin
                errors++;
                $display("FAIL basic_word%0d: got %h expected %h", k, mem[128 + k], want);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_done: got %0d pulses expected 1", done_cnt);
        end
        checks++;
        if (done_cyc - first_stb !== 24) begin
            errors++;
            $display("FAIL basic_cycles: got %0d expected 24", done_cyc - first_stb);
        end
        checks++;
        if (stb_cycles !== 16) begin
            errors++;
            $display("FAIL basic_stb: got %0d expected 16", stb_cycles);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL basic_protocol: got %0d violations expected 0", viol);
        end
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle: got busy,err=%b expected 00", {busy, err});
        end
        checks++;
        if (mem_diff() !== 0) begin
            errors++;
            $display("FAIL basic_image: got %0d bad words expected 0", mem_diff());
        end
    endtask

    task automatic test_zero_len();
        clear_stats();
        @(negedge clk);
        src   = 32'h100;
        dst   = 32'h200;
        len   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL zero_done: got done,busy=%b expected 11", {done, busy});
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_after: got done,busy=%b expected 00", {done, busy});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stb_cycles !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL zero_bus: got stb=%0d done=%0d expected 0 1",
                     stb_cycles, done_cnt);
        end
    endtask

    task automatic test_ignore_start();
        fill_random();
        model_copy(32'h040, 32'h600, 5);
        clear_stats();
        start_copy(32'h040, 32'h600, 5);
        repeat (7) @(negedge clk);
        src   = 32'h080;
        dst   = 32'h700;
        len   = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_done: got %0d pulses expected 1", done_cnt);
        end
        checks++;
        if (mem_diff() !== 0) begin
            errors++;
            $display("FAIL ignore_image: got %0d bad words expected 0", mem_diff());
        end
        checks++;
        if (done_cyc - first_stb !== 30) begin
            errors++;
            $display("FAIL ignore_cycles: got %0d expected 30", done_cyc - first_stb);
        end
        checks++;
        if (rd_q.size() != 5 || rd_q[4] !== 32'h050) begin
            errors++;
            $display("FAIL ignore_reads: got %0d reads expected 5 ending at 50",
                     rd_q.size());
        end
    endtask

    task automatic test_wrap();
        fill_random();
        model_copy(32'hFFFF_FFFC, 32'h300, 2);
        clear_stats();
        start_copy(32'hFFFF_FFFC, 32'h300, 2);
        wait_done(100);
        checks++;
        if (rd_q.size() < 2 || rd_q[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_adr: got %0d reads expected second at 0", rd_q.size());
        end
        checks++;
        if (mem_diff() !== 0) begin
            errors++;
            $display("FAIL wrap_image: got %0d bad words expected 0", mem_diff());
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic [31:0] d;
        int          n;
        for (int it = 0; it < 8; it++) begin
            s = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(0, 3));
            d = 32'h800 + 32'($urandom_range(0, 247)) * 32'd4 + 32'($urandom_range(0, 3));
            n = $urandom_range(1, 8);
            stray_en = 1'($urandom_range(0, 1));
            fill_random();
            model_copy(s, d, n);
            clear_stats();
            start_copy(s, d, LEN_W'(n));
            wait_done(6 * n + 40);
            checks++;
            if (done_cnt !== 1 || mem_diff() !== 0) begin
                errors++;
                $display("FAIL rand%0d_copy: got done=%0d bad=%0d expected 1 0",
                         it, done_cnt, mem_diff());
            end
            checks++;
            if (done_cyc - first_stb !== 6 * n || stb_cycles !== 4 * n) begin
                errors++;
                $display("FAIL rand%0d_timing: got %0d/%0d expected %0d/%0d",
                         it, done_cyc - first_stb, stb_cycles, 6 * n, 4 * n);
            end
            checks++;
            if (viol !== 0) begin
                errors++;
                $display("FAIL rand%0d_protocol: got %0d expected 0", it, viol);
            end
        end
        stray_en = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic found;
        fill_random();
        mem[256] = 32'hA5A5_A5A5;
        mem[4]   = 32'h5A5A_5A5A;
        clear_stats();
        start_copy(32'h010, 32'h400, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (wb_stb && wb_we) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_reach_wr: got no write strobe expected one");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_stb, wb_cyc, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: got stb,cyc,busy=%b expected 000",
                     {wb_stb, wb_cyc, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        repeat (20) @(negedge clk);
        checks++;
        if (mem[256] !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL rst_dst: got %h expected a5a5a5a5", mem[256]);
        end
        checks++;
        if (busy !== 1'b0 || stb_cycles !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL rst_resume: got busy=%b stb=%0d done=%0d expected 0 0 0",
                     busy, stb_cycles, done_cnt);
        end
    endtask

`ifdef WB_DMA_TIMEOUT_EN
    task automatic test_timeout();
        fill_random();
        model_copy(32'h100, 32'h200, 0);
        ack_en = 1'b0;
        clear_stats();
        start_copy(32'h100, 32'h200, 2);
        wait_done(100);
        checks++;
        if (stb_cycles !== TIMEOUT) begin
            errors++;
            $display("FAIL tmo_stb: got %0d expected %0d", stb_cycles, TIMEOUT);
        end
        checks++;
        if (done_cnt !== 1 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_flags: got done=%0d err=%b busy=%b expected 1 1 0",
                     done_cnt, err, busy);
        end
        checks++;
        if (mem_diff() !== 0) begin
            errors++;
            $display("FAIL tmo_image: got %0d bad words expected 0", mem_diff());
        end
        ack_en = 1'b1;
        @(negedge clk);
        len   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: got err=%b expected 0", err);
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_ignore_start();
        test_wrap();
        test_random();
        test_reset_mid_write();
`ifdef WB_DMA_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_dma_copy.md
WB_DMA_COPY -- requirements
Module: wb_dma_copy

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of word-count input.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for i_wb_ack per transfer.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_start  input  1  start request, sampled when idle.
REQ-006 SHALL have port i_src  input  32  source byte address.
REQ-007 SHALL have port i_dst  input  32  destination byte address.
REQ-008 SHALL have port i_len  input  LEN_W  number of 32-bit words to copy.
REQ-009 SHALL have port o_busy  output  1  copy in progress.
REQ-010 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_err  output  1  sticky timeout flag, cleared by next accepted i_start.
REQ-012 SHALL have Wishbone initiator ports: o_wb_adr output 32, o_wb_dat output 32, o_wb_sel output 4, o_wb_we output 1, o_wb_stb output 1, o_wb_cyc output 1, i_wb_rdt input 32, i_wb_ack input 1.

Function
REQ-013 SHALL implement states IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
REQ-014 IDLE: i_start=1 SHALL latch i_src/i_dst/i_len (low 2 address bits forced 0), clear o_err, go RD; i_len=0 SHALL go DONE directly with no bus cycle.
REQ-015 i_start while o_busy=1 SHALL be ignored.
REQ-016 RD: o_wb_stb=o_wb_cyc=1, o_wb_we=0, o_wb_adr=current source; on i_wb_ack SHALL capture i_wb_rdt into data register and go RD_GAP.
REQ-017 RD_GAP / WR_GAP: stb and cyc SHALL be 0 for exactly one cycle between consecutive transfers.
REQ-018 WR: stb=cyc=1, we=1, o_wb_sel=4'hF, o_wb_dat=captured word, o_wb_adr=current destination; on ack SHALL go WR_GAP.
REQ-019 WR_GAP SHALL increment both addresses by 4 (modulo 2^32, wrap to 0), decrement count, go DONE if count reaches 0 else RD.
REQ-020 All bus outputs SHALL be registered; stb held stable with constant adr/dat/we until ack.
REQ-021 With a responder acking one cycle after stb, SHALL take exactly 6 cycles per word from first stb to next read stb.
REQ-022 DONE: o_done=1 for exactly one cycle, then IDLE; o_busy=1 in every state except IDLE.
REQ-023 i_wb_ack when stb=0 SHALL be ignored.

Reset
REQ-024 i_rst_n=0 SHALL immediately force state IDLE and o_busy, o_done, o_err, o_wb_stb, o_wb_cyc, o_wb_we to 0, o_wb_sel, o_wb_adr, o_wb_dat to 0, including mid-transfer.
REQ-025 Deassertion SHALL take effect on the next rising i_clk; no transfer resumes.

Configuration
REQ-026 Macro WB_DMA_TIMEOUT_EN defined: per-transfer counter SHALL abort after TIMEOUT cycles of stb without ack -> drop stb/cyc next cycle, set o_err, go DONE (o_done pulses).
REQ-027 Macro undefined: SHALL wait indefinitely for ack; o_err tied 0; no counter logic.

Structure
REQ-028 Package wb_dma_pkg SHALL hold state enum and localparam WORD_BYTES=4, SEL_ALL=4'hF.
REQ-029 No sub-module; timeout counter inline.

Verification
REQ-030 wb_ram responder, words 0x11111111..0x44444444 at 0x100, i_src=0x100, i_dst=0x200, i_len=4 -> 0x200..0x20C hold same data, o_done one pulse, 24 bus cycles.
REQ-031 i_len=0 -> o_done pulse the cycle after start, o_wb_stb never 1.
REQ-032 i_start pulsed mid-copy with different addresses -> ignored, original copy completes unchanged.
REQ-033 WB_DMA_TIMEOUT_EN, TIMEOUT=16, responder never acks -> stb drops after 16 cycles, o_err=1, o_done pulses; next i_start clears o_err.
REQ-034 i_rst_n low during WR -> stb/cyc/busy 0 before next clock edge; destination word unwritten.
REQ-035 i_src=0xFFFFFFFC, i_len=2 -> second read o_wb_adr=0x00000000.
